l1_buffer_fill_controller: RTL and testbench

- Write-side controller for the per-lane L1 buffer.
- Accepts full-width rows (one element per lane) from the L2/DMA stream over a valid/ready handshake.
- Issues the buffer's enable, write, write-index and data-in signals for a programmed burst of rows starting at a base index.
- Arbitrates against the read side: a read request always wins the single shared buffer port for that cycle.

---
 rtl/l1_buffer_fill_controller.sv | 114 +++++++++++
 tb/tb_l1_buffer_fill_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_buffer_fill_controller.sv
`default_nettype none
// ============================================================================
// Module   : l1_buffer_fill_controller
// Purpose  : Write-side burst controller for the per-lane L1 buffer; the read
//            side always takes priority on the shared buffer port.
// Revision : 1.0 - initial release
// ============================================================================
module l1_buffer_fill_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_COUNT = 4,
    parameter int DATA_DEPTH = 16,
    parameter int IW         = $clog2(DATA_DEPTH),
    parameter int CW         = $clog2(DATA_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IW-1:0]         base_index,
    input  logic [CW-1:0]         num_rows,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data [0:LANE_COUNT-1],
    output logic                  in_ready,
    input  logic                  read_req,
    output logic                  buf_enable,
    output logic                  buf_write,
    output logic [IW-1:0]         buf_write_index,
    output logic [DATA_WIDTH-1:0] buf_data_in [0:LANE_COUNT-1],
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         rows_written
);

    localparam logic [CW-1:0] c_depth_cnt = CW'(DATA_DEPTH);
    localparam logic [IW-1:0] c_last_idx  = IW'(DATA_DEPTH - 1);
    localparam logic [CW-1:0] c_one_cnt   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_index;
    logic [CW-1:0]   r_remaining;
    logic [CW-1:0]   r_rows_written;
    logic [CW-1:0]   w_sat_rows;
    logic            w_launch;

    assign w_sat_rows = (num_rows > c_depth_cnt) ? c_depth_cnt : num_rows;
    assign w_launch   = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        buf_write   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_sat_rows != '0) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                // The read side owns the port whenever it asks for it.
                in_ready  = ~read_req;
                buf_write = in_valid & ~read_req;
                if (buf_write && (r_remaining == c_one_cnt)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index        <= '0;
            r_remaining    <= '0;
            r_rows_written <= '0;
        end else if (w_launch) begin
            r_index        <= base_index;
            r_remaining    <= w_sat_rows;
            r_rows_written <= '0;
        end else if (buf_write) begin
            // Explicit wrap so non power-of-two depths work.
            r_index        <= (r_index == c_last_idx) ? '0 : r_index + IW'(1);
            r_remaining    <= r_remaining - c_one_cnt;
            r_rows_written <= r_rows_written + c_one_cnt;
        end
    end

    assign buf_enable      = buf_write | read_req;
    assign buf_write_index = r_index;
    assign buf_data_in     = in_data;
    assign busy            = (r_state == ST_FILL);
    assign done            = (r_state == ST_DONE);
    assign rows_written    = r_rows_written;

endmodule
`default_nettype wire

// File: tb/tb_l1_buffer_fill_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_buffer_fill_controller
// Purpose  : Scoreboard bench for l1_buffer_fill_controller with directed bursts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_buffer_fill_controller;

    localparam int DW    = 8;
    localparam int LC    = 4;
    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam int CW    = 5;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] base_index;
    logic [CW-1:0] num_rows;
    logic          in_valid;
    logic [DW-1:0] in_data [0:LC-1];
    logic          in_ready;
    logic          read_req;
    logic          buf_enable;
    logic          buf_write;
    logic [IW-1:0] buf_write_index;
    logic [DW-1:0] buf_data_in [0:LC-1];
    logic          busy;
    logic          done;
    logic [CW-1:0] rows_written;

    l1_buffer_fill_controller #(
        .DATA_WIDTH(DW),
        .LANE_COUNT(LC),
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_index     (base_index),
        .num_rows       (num_rows),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .read_req       (read_req),
        .buf_enable     (buf_enable),
        .buf_write      (buf_write),
        .buf_write_index(buf_write_index),
        .buf_data_in    (buf_data_in),
        .busy           (busy),
        .done           (done),
        .rows_written   (rows_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0]    idx;
        logic [DW*LC-1:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DW*LC-1:0] pack_out();
        logic [DW*LC-1:0] v;
        for (int i = 0; i < LC; i++) v[DW*i +: DW] = buf_data_in[i];
        return v;
    endfunction

    // Monitor: every write and every done pulse must match the next expectation.
    always @(negedge clk) begin
        wr_t e;
        int  r;
        if (buf_write) begin
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual index=%0d required=no write", buf_write_index);
            end else begin
                e = exp_wr.pop_front();
                check("wr_index", 64'(buf_write_index), 64'(e.idx));
                check("wr_data", 64'(pack_out()), 64'(e.data));
                check("wr_enable", 64'(buf_enable), 64'd1);
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: actual=1 required=0");
            end else begin
                r = exp_done.pop_front();
                check("done_rows", 64'(rows_written), 64'(r));
                check("done_busy", 64'(busy), 64'd0);
            end
        end
    end

    // Entry and exit of every task: 1 time unit after a rising edge.
    task automatic do_start(input logic [IW-1:0] b, input logic [CW-1:0] n);
        start = 1'b1; base_index = b; num_rows = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_row(input logic [DW*LC-1:0] d);
        in_valid = 1'b1;
        for (int i = 0; i < LC; i++) in_data[i] = d[DW*i +: DW];
    endtask

    task automatic send_row(input logic [IW-1:0] idx, input logic [DW*LC-1:0] d);
        bit ok;
        ok = 1'b0;
        exp_wr.push_back({idx, d});
        drive_row(d);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual in_ready=0 required=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_wr.size() == 0 && exp_done.size() == 0 && !busy && !done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout: actual pending=%0d required=0", name, exp_wr.size() + exp_done.size());
        end
    endtask

    function automatic logic [DW*LC-1:0] row(input int n);
        return 32'hA0B0C0D0 + 32'(n * 32'h01010101);
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; base_index = '0; num_rows = '0;
        in_valid = 1'b1; read_req = 1'b0;
        for (int i = 0; i < LC; i++) in_data[i] = '0;
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_buf_write", 64'(buf_write), 64'd0);
        check("rst_rows_written", 64'(rows_written), 64'd0);
        check("rst_index", 64'(buf_write_index), 64'd0);
        read_req = 1'b1;
        #1;
        check("rst_enable_follows_read", 64'(buf_enable), 64'd1);
        read_req = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst
        exp_done.push_back(3);
        do_start(4'd2, 5'd3);
        check("basic_busy", 64'(busy), 64'd1);
        send_row(4'd2, row(0));
        send_row(4'd3, row(1));
        send_row(4'd4, row(2));
        check("basic_done_next_cycle", 64'(done), 64'd1);
        drain("basic");
        check("basic_rows_written", 64'(rows_written), 64'd3);

        // Index wrap
        exp_done.push_back(4);
        do_start(4'd14, 5'd4);
        send_row(4'd14, row(3));
        send_row(4'd15, row(4));
        send_row(4'd0, row(5));
        send_row(4'd1, row(6));
        drain("wrap");
        check("wrap_rows_written", 64'(rows_written), 64'd4);

        // Read priority on second beat
        exp_done.push_back(3);
        do_start(4'd2, 5'd3);
        send_row(4'd2, row(7));
        read_req = 1'b1;
        drive_row(row(8));
        @(negedge clk);
        check("arb_in_ready", 64'(in_ready), 64'd0);
        check("arb_buf_write", 64'(buf_write), 64'd0);
        check("arb_buf_enable", 64'(buf_enable), 64'd1);
        check("arb_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        read_req = 1'b0;
        send_row(4'd3, row(8));
        send_row(4'd4, row(9));
        drain("arb");

        // Zero-length burst
        exp_done.push_back(0);
        do_start(4'd7, 5'd0);
        in_valid = 1'b1;
        drain("zero");
        in_valid = 1'b0;

        // Oversized burst saturates to depth
        exp_done.push_back(16);
        do_start(4'd0, 5'd20);
        for (int i = 0; i < DEPTH; i++) send_row(IW'(i), row(20 + i));
        in_valid = 1'b1;
        drain("sat");
        in_valid = 1'b0;
        check("sat_rows_written", 64'(rows_written), 64'd16);

        // Upstream bubbles and ignored mid-burst start
        exp_done.push_back(3);
        do_start(4'd10, 5'd3);
        send_row(4'd10, row(40));
        start = 1'b1; base_index = 4'd0; num_rows = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        send_row(4'd11, row(41));
        @(posedge clk); #1;
        send_row(4'd12, row(42));
        drain("bubble");
        check("bubble_rows_written", 64'(rows_written), 64'd3);

        // Reset mid-burst, no done pulse
        do_start(4'd5, 5'd5);
        send_row(4'd5, row(50));
        send_row(4'd6, row(51));
        drive_row(row(52));
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd0);
        check("mrst_buf_write", 64'(buf_write), 64'd0);
        check("mrst_rows_written", 64'(rows_written), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_done.push_back(2);
        do_start(4'd9, 5'd2);
        send_row(4'd9, row(60));
        send_row(4'd10, row(61));
        drain("post_rst");

        repeat (3) @(posedge clk);
        #1;
        check("end_writes_pending", 64'(exp_wr.size()), 64'd0);
        check("end_done_pending", 64'(exp_done.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
